branch_redirect_unit: RTL and testbench
=======================================

Name: branch_redirect_unit

Overview:
EX-stage control-flow resolver and redirect sequencer that drives the PC counter's control inputs. It takes decoded branch/jump operands from the ID/EX register and evaluates the branch condition. It then registers one pending redirect and presents it to the PC counter until the counter accepts it, while flushing wrong-path fetch/decode slots. It is the producer side of the PC counter's en/type/pc_EX/imm/rs1 interface.

Parameters:
XLEN, 32, datapath and PC width
CNT_W, 32, width of redirect performance counter

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  synchronous, active-high reset
ex_valid  in  1  EX holds a real instruction this cycle (one-cycle qualifier per instruction)
ex_op  in  4  control-flow op (package enum)
ex_pc  in  XLEN  PC of EX instruction
ex_imm  in  XLEN  sign-extended immediate
ex_rs1_val  in  XLEN  forwarded rs1 value
ex_rs2_val  in  XLEN  forwarded rs2 value
pc_stall  in  1  hazard unit requests PC hold
pc_en  out  1  PC counter enable
pc_type  out  2  00 sequential (+4), 01 pc_ex+pc_imm, 11 pc_imm+pc_rs1
pc_ex  out  XLEN  base PC for type 01
pc_imm  out  XLEN  offset / absolute target
pc_rs1  out  XLEN  register operand for type 11
flush_if_id  out  1  squash IF/ID register this cycle
flush_id_ex  out  1  squash ID/EX register this cycle
link_value  out  XLEN  ex_pc+4 for JAL/JALR writeback (combinational)
misalign_err  out  1  one-cycle pulse: taken target not 4-byte aligned
redirect_cnt  out  CNT_W  number of issued redirects

Behaviour:
- Ops: NONE, BEQ, BNE, BLT, BGE (signed), BLTU, BGEU (unsigned), JAL, JALR. Unlisted codes behave as NONE.
- Taken = ex_valid && state==IDLE && (JAL || JALR || the branch condition is true).
- Target is ex_pc+ex_imm, except JALR, which uses (ex_rs1_val+ex_imm) with bit0 cleared. All sums are mod 2^XLEN; wrap-around is legal.
- Resolve cycle, taken and target[1:0]==0:
  - Register the redirect: type 01 with {ex_pc, ex_imm} for branch/JAL; type 11 with pc_imm=target, pc_rs1=0 for JALR.
  - Enter ISSUE.
  - Assert flush_if_id and flush_id_ex combinationally in the same cycle.
- Resolve cycle, taken and target misaligned: misalign_err=1 next cycle, no redirect, no flush, stay IDLE.
- IDLE outputs: pc_en=~pc_stall, pc_type=00, pc_ex/pc_imm/pc_rs1=0.
- ISSUE:
  - Drive the registered type/operands.
  - pc_en=~pc_stall.
  - flush_if_id=flush_id_ex=1 every ISSUE cycle.
  - ex_valid is ignored (wrong path).
  - On a cycle with pc_stall=0: return to IDLE next edge and increment redirect_cnt.
  - pc_stall=1 holds ISSUE indefinitely with operands stable.
- Latency: resolve at cycle N, PC loaded at end of N+1 if unstalled. Penalty is 2 squashed slots.
- Non-taken branch/NONE: no state change, no flush.
- redirect_cnt wraps at 2^CNT_W.
- Reset: state=IDLE, registered operands=0, misalign_err=0, redirect_cnt=0.
  - Outputs during/after rst: pc_en=~pc_stall, pc_type=00, flushes=0.
  - rst while in ISSUE drops the pending redirect; rst dominates all simultaneous events.

Decomposition:
- Package riscv_branch_pkg holds:
  - ex_op enum values (NONE=0, BEQ, BNE, BLT, BGE, BLTU, BGEU, JAL, JALR)
  - pc_type constants PC_SEQ=2'b00, PC_BRANCH=2'b01, PC_JALR=2'b11
  - FSM state enum {IDLE, ISSUE}
- One sub-module: branch_compare, a purely combinational block with inputs op, a, b and output taken.

Test Plan:
- BEQ, ex_pc=0x100, imm=0x20, rs1=rs2=5, no stall -> cycle N flushes=1; N+1 pc_type=01, pc_ex=0x100, pc_imm=0x20, pc_en=1, flushes=1; N+2 IDLE, redirect_cnt=1.
- BLT rs1=0xFFFFFFFF, rs2=1 -> taken; BLTU same operands -> not taken, pc_type stays 00, no flush.
- JALR rs1=0x1003, imm=0x4 -> pc_type=11, pc_imm=0x1006? misaligned ([1]=1) -> misalign_err pulse, no redirect. Repeat with rs1=0x1001, imm=0x3 -> pc_imm=0x1004, pc_rs1=0, link_value=ex_pc+4.
- JAL taken, pc_stall=1 for 3 cycles in ISSUE -> pc_en=0, operands stable, flushes held; ex_valid pulses ignored; stall drop -> pc_en=1 one cycle, then IDLE.
- rst asserted during ISSUE -> next cycle IDLE, pc_type=00, redirect_cnt=0, no redirect issued.
- JAL ex_pc=0xFFFFFFF0, imm=0x20 -> target wraps to 0x10, redirect issued normally.

Source files
------------

// File: rtl/branch_redirect_unit_pkg.sv
`default_nettype none
// ============================================================================
// riscv_branch_pkg : control-flow op codes, PC-counter type codes, FSM states
// Revision: 1.0
// ============================================================================
package riscv_branch_pkg;

  typedef enum logic [3:0] {
    OP_NONE = 4'd0,
    OP_BEQ  = 4'd1,
    OP_BNE  = 4'd2,
    OP_BLT  = 4'd3,
    OP_BGE  = 4'd4,
    OP_BLTU = 4'd5,
    OP_BGEU = 4'd6,
    OP_JAL  = 4'd7,
    OP_JALR = 4'd8
  } ex_op_e;

  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_BRANCH = 2'b01;
  localparam logic [1:0] PC_JALR   = 2'b11;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } state_e;

endpackage : riscv_branch_pkg
`default_nettype wire

// File: rtl/branch_redirect_unit_compare.sv
`default_nettype none
// ============================================================================
// branch_compare : combinational branch-condition evaluator (jumps always taken)
// Revision: 1.0
// ============================================================================
module branch_compare
  import riscv_branch_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [3:0]      op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            taken
);

  always_comb begin
    taken = 1'b0;
    case (op)
      OP_BEQ:  taken = (a == b);
      OP_BNE:  taken = (a != b);
      OP_BLT:  taken = ($signed(a) <  $signed(b));
      OP_BGE:  taken = ($signed(a) >= $signed(b));
      OP_BLTU: taken = (a <  b);
      OP_BGEU: taken = (a >= b);
      OP_JAL,
      OP_JALR: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule : branch_compare
`default_nettype wire

// File: rtl/branch_redirect_unit.sv
`default_nettype none
// ============================================================================
// branch_redirect_unit : EX-stage branch resolver and single-entry redirect
//                        sequencer feeding the PC counter control interface
// Revision: 1.0
// ============================================================================
module branch_redirect_unit
  import riscv_branch_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ex_valid,
  input  logic [3:0]       ex_op,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [XLEN-1:0]  ex_imm,
  input  logic [XLEN-1:0]  ex_rs1_val,
  input  logic [XLEN-1:0]  ex_rs2_val,
  input  logic             pc_stall,
  output logic             pc_en,
  output logic [1:0]       pc_type,
  output logic [XLEN-1:0]  pc_ex,
  output logic [XLEN-1:0]  pc_imm,
  output logic [XLEN-1:0]  pc_rs1,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic [XLEN-1:0]  link_value,
  output logic             misalign_err,
  output logic [CNT_W-1:0] redirect_cnt
);

  state_e           state_q, state_d;
  logic [1:0]       type_q, type_d;
  logic [XLEN-1:0]  ex_q, ex_d;
  logic [XLEN-1:0]  imm_q, imm_d;
  logic [XLEN-1:0]  rs1_q, rs1_d;
  logic             misalign_q, misalign_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             cond_taken;
  logic             is_jalr;
  logic [XLEN-1:0]  target;
  logic             resolve_taken;
  logic             redirect_go;
  logic             misalign_go;
  logic             issue_active;

  branch_compare #(.XLEN(XLEN)) u_cmp (
    .op    (ex_op),
    .a     (ex_rs1_val),
    .b     (ex_rs2_val),
    .taken (cond_taken)
  );

  assign is_jalr = (ex_op == OP_JALR);
  assign target  = is_jalr ? ((ex_rs1_val + ex_imm) & ~XLEN'(1)) : (ex_pc + ex_imm);

  // Only an idle unit resolves; while ISSUE is pending EX holds a wrong-path op.
  assign resolve_taken = ex_valid && (state_q == IDLE) && cond_taken;
  assign redirect_go   = resolve_taken && (target[1:0] == 2'b00);
  assign misalign_go   = resolve_taken && (target[1:0] != 2'b00);

  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    ex_d       = ex_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    cnt_d      = cnt_q;
    misalign_d = 1'b0;
    case (state_q)
      IDLE: begin
        misalign_d = misalign_go;
        if (redirect_go) begin
          state_d = ISSUE;
          rs1_d   = '0;
          if (is_jalr) begin
            type_d = PC_JALR;
            ex_d   = '0;
            imm_d  = target;
          end else begin
            type_d = PC_BRANCH;
            ex_d   = ex_pc;
            imm_d  = ex_imm;
          end
        end
      end
      ISSUE: begin
        if (!pc_stall) begin
          state_d = IDLE;
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      type_q     <= PC_SEQ;
      ex_q       <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      misalign_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      ex_q       <= ex_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      misalign_q <= misalign_d;
      cnt_q      <= cnt_d;
    end
  end

  // Reset masks a pending redirect immediately, not just from the next edge.
  assign issue_active = (state_q == ISSUE) && !rst;

  assign pc_en        = ~pc_stall;
  assign pc_type      = issue_active ? type_q : PC_SEQ;
  assign pc_ex        = issue_active ? ex_q   : '0;
  assign pc_imm       = issue_active ? imm_q  : '0;
  assign pc_rs1       = issue_active ? rs1_q  : '0;
  assign flush_if_id  = issue_active || (redirect_go && !rst);
  assign flush_id_ex  = issue_active || (redirect_go && !rst);
  assign link_value   = ex_pc + XLEN'(4);
  assign misalign_err = misalign_q;
  assign redirect_cnt = cnt_q;

endmodule : branch_redirect_unit
`default_nettype wire

// File: tb/tb_branch_redirect_unit.sv
`default_nettype none
// ============================================================================
// tb_branch_redirect_unit : randomized + directed scoreboard bench
// Revision: 1.0
// ============================================================================
module tb_branch_redirect_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [3:0]  ex_op;
  logic [31:0] ex_pc, ex_imm, ex_rs1_val, ex_rs2_val;
  logic        pc_stall;
  logic        pc_en;
  logic [1:0]  pc_type;
  logic [31:0] pc_ex, pc_imm, pc_rs1, link_value, redirect_cnt;
  logic        flush_if_id, flush_id_ex, misalign_err;

  branch_redirect_unit #(.XLEN(32), .CNT_W(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid     (ex_valid),
    .ex_op        (ex_op),
    .ex_pc        (ex_pc),
    .ex_imm       (ex_imm),
    .ex_rs1_val   (ex_rs1_val),
    .ex_rs2_val   (ex_rs2_val),
    .pc_stall     (pc_stall),
    .pc_en        (pc_en),
    .pc_type      (pc_type),
    .pc_ex        (pc_ex),
    .pc_imm       (pc_imm),
    .pc_rs1       (pc_rs1),
    .flush_if_id  (flush_if_id),
    .flush_id_ex  (flush_id_ex),
    .link_value   (link_value),
    .misalign_err (misalign_err),
    .redirect_cnt (redirect_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit        en;
    bit [1:0]  ptype;
    bit [31:0] pex, pimm, prs1, link, cnt;
    bit        fif, fid, mis;
  } exp_t;

  typedef struct {
    bit [1:0]  ptype;
    bit [31:0] pex, pimm, prs1;
  } redir_t;

  exp_t   cycle_q[$];
  redir_t red_q[$];

  int total = 0;
  int bad   = 0;

  // Reference model: one optional pending redirect, a misalign flag, a counter.
  bit        m_pend;
  redir_t    m_rec;
  bit        m_mis;
  bit [31:0] m_cnt;

  function automatic bit ref_taken(input int op, input bit [31:0] a, input bit [31:0] b);
    case (op)
      1: return a == b;
      2: return a != b;
      3: return $signed(a) < $signed(b);
      4: return $signed(a) >= $signed(b);
      5: return a < b;
      6: return a >= b;
      7, 8: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cycle_q.size() > 0) begin
      exp_t e;
      e = cycle_q.pop_front();
      chk("pc_en",        32'(pc_en),        32'(e.en));
      chk("pc_type",      32'(pc_type),      32'(e.ptype));
      chk("pc_ex",        pc_ex,             e.pex);
      chk("pc_imm",       pc_imm,            e.pimm);
      chk("pc_rs1",       pc_rs1,            e.prs1);
      chk("flush_if_id",  32'(flush_if_id),  32'(e.fif));
      chk("flush_id_ex",  32'(flush_id_ex),  32'(e.fid));
      chk("link_value",   link_value,        e.link);
      chk("misalign_err", 32'(misalign_err), 32'(e.mis));
      chk("redirect_cnt", redirect_cnt,      e.cnt);
    end
    // A redirect handed to the PC counter must match the oldest resolved one.
    if (pc_en === 1'b1 && pc_type !== 2'b00) begin
      if (red_q.size() == 0) begin
        chk("spurious_redirect", 32'(pc_type), 32'h0);
      end else begin
        redir_t r;
        r = red_q.pop_front();
        chk("accept_type", 32'(pc_type), 32'(r.ptype));
        chk("accept_ex",   pc_ex,        r.pex);
        chk("accept_imm",  pc_imm,       r.pimm);
        chk("accept_rs1",  pc_rs1,       r.prs1);
      end
    end
  end

  task automatic step(input bit r, input bit v, input bit [3:0] op, input bit [31:0] pc,
                      input bit [31:0] imm, input bit [31:0] a, input bit [31:0] b,
                      input bit stall);
    exp_t      e;
    bit        tk, al;
    bit [31:0] tgt;
    rst = r; ex_valid = v; ex_op = op; ex_pc = pc; ex_imm = imm;
    ex_rs1_val = a; ex_rs2_val = b; pc_stall = stall;

    tk  = v && !m_pend && ref_taken(int'(op), a, b);
    tgt = (op == 4'd8) ? ((a + imm) & 32'hFFFF_FFFE) : (pc + imm);
    al  = (tgt % 4) == 0;

    e.en = !stall; e.link = pc + 32'd4; e.mis = m_mis; e.cnt = m_cnt;
    e.ptype = 2'b00; e.pex = 0; e.pimm = 0; e.prs1 = 0; e.fif = 0; e.fid = 0;
    if (!r && m_pend) begin
      e.ptype = m_rec.ptype; e.pex = m_rec.pex; e.pimm = m_rec.pimm; e.prs1 = m_rec.prs1;
      e.fif = 1; e.fid = 1;
    end else if (!r) begin
      e.fif = tk && al; e.fid = tk && al;
    end
    cycle_q.push_back(e);

    @(posedge clk);
    if (r) begin
      if (m_pend && red_q.size() > 0) void'(red_q.pop_back());
      m_pend = 0; m_mis = 0; m_cnt = 0;
    end else if (m_pend) begin
      m_mis = 0;
      if (!stall) begin
        m_pend = 0;
        m_cnt  = m_cnt + 1;
      end
    end else begin
      m_mis = tk && !al;
      if (tk && al) begin
        m_pend = 1;
        if (op == 4'd8) begin
          m_rec.ptype = 2'b11; m_rec.pex = 0; m_rec.pimm = tgt;
        end else begin
          m_rec.ptype = 2'b01; m_rec.pex = pc; m_rec.pimm = imm;
        end
        m_rec.prs1 = 0;
        red_q.push_back(m_rec);
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit [3:0]  op;
    bit [31:0] pc, imm, a, b;
    m_pend = 0; m_mis = 0; m_cnt = 0;
    rst = 1; ex_valid = 0; ex_op = 0; ex_pc = 0; ex_imm = 0;
    ex_rs1_val = 0; ex_rs2_val = 0; pc_stall = 0;
    @(posedge clk); #1;
    step(1, 0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0, 0);
    step(1, 0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1);

    // BEQ taken, unstalled: flush, issue, back to idle with count 1
    step(0, 1, 4'd1, 32'h100, 32'h20, 32'd5, 32'd5, 0);
    idle(2);
    // BLT signed taken vs BLTU not taken on the same operands
    step(0, 1, 4'd3, 32'h200, 32'h40, 32'hFFFF_FFFF, 32'd1, 0);
    idle(1);
    step(0, 1, 4'd5, 32'h300, 32'h40, 32'hFFFF_FFFF, 32'd1, 0);
    idle(1);
    // JALR misaligned then aligned
    step(0, 1, 4'd8, 32'h400, 32'h4, 32'h1003, 32'h0, 0);
    idle(1);
    step(0, 1, 4'd8, 32'h404, 32'h3, 32'h1001, 32'h0, 0);
    idle(1);
    // JAL with a 3-cycle stall in ISSUE and wrong-path ex_valid pulses
    step(0, 1, 4'd7, 32'h500, 32'h80, 32'h0, 32'h0, 0);
    step(0, 1, 4'd7, 32'h600, 32'h10, 32'h0, 32'h0, 1);
    step(0, 1, 4'd1, 32'h604, 32'h10, 32'h1, 32'h1, 1);
    step(0, 0, 4'd8, 32'h608, 32'h10, 32'h8, 32'h0, 1);
    step(0, 1, 4'd7, 32'h60C, 32'h10, 32'h0, 32'h0, 0);
    idle(1);
    // Reset while in ISSUE drops the redirect and the count
    step(0, 1, 4'd7, 32'h700, 32'h8, 32'h0, 32'h0, 0);
    step(1, 0, 4'd0, 32'h0, 32'h0, 32'h0, 32'h0, 1);
    idle(2);
    // JAL target wraps around the address space
    step(0, 1, 4'd7, 32'hFFFF_FFF0, 32'h20, 32'h0, 32'h0, 0);
    idle(2);

    for (int i = 0; i < 2500; i++) begin
      op  = ($urandom_range(0, 3) != 0) ? 4'($urandom_range(0, 8)) : 4'($urandom_range(0, 15));
      pc  = $urandom & 32'hFFFF_FFFC;
      imm = ($urandom_range(0, 3) == 0) ? 32'($urandom) : (32'($urandom) & 32'hFFFF_F0FC);
      a   = ($urandom_range(0, 2) == 0) ? 32'($urandom_range(0, 7)) : 32'($urandom);
      b   = ($urandom_range(0, 2) == 0) ? a : 32'($urandom);
      step($urandom_range(0, 49) == 0, $urandom_range(0, 3) != 0, op, pc, imm, a, b,
           $urandom_range(0, 9) < 3);
    end
    idle(3);

    for (int i = 0; i < 10 && cycle_q.size() > 0; i++) @(posedge clk);
    chk("cycle_queue_drained", 32'(cycle_q.size()), 32'h0);
    chk("redirect_queue_drained", 32'(red_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_branch_redirect_unit
`default_nettype wire
